gost_engine: RTL and testbench

GOST_ENGINE -- requirements
Module: gost_engine

---
 rtl/gost_engine.sv | 157 +++++++++++++++
 tb/tb_gost_engine.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gost_engine.sv
// GOST R 34.12-2015 "Magma" 64-bit block engine: ECB encrypt/decrypt and CTR.
// One block in flight, ROUNDS_PER_CYCLE unrolled rounds per RUN clock.
module gost_engine #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         iclk,
   input  logic         irst_n,
   input  logic [1:0]   imode,
   input  logic [255:0] ikey,
   input  logic [31:0]  iiv,
   input  logic         iiv_load,
   input  logic [63:0]  iblock,
   input  logic         ivalid,
   output logic         oready,
   output logic [63:0]  oblock,
   output logic         ovalid,
   input  logic         iready,
   output logic         obusy
);

   localparam int R = ROUNDS_PER_CYCLE;

   // pi'0..pi'7, nibble j of each word is pi'[j]
   localparam logic [511:0] SBOX = {
      64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8,
      64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
      64'hB9E35A076F4D128C, 64'h069C471EDAF2853B,
      64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   generate
      if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rpc
         $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
      end
   endgenerate

   function automatic logic [31:0] g_fn(input logic [31:0] a,
                                        input logic [31:0] k);
      logic [31:0] t;
      logic [31:0] s;
      t = a + k;
      s = '0;
      for (int n = 0; n < 8; n++)
         s[4*n +: 4] = SBOX[64*n + 4*t[4*n +: 4] +: 4];
      return {s[20:0], s[31:21]};
   endfunction

   // Decrypt runs the encrypt key schedule backwards: the descending
   // K8..K1 pass sits at rounds 24-31 for encrypt and 8-31 for decrypt.
   function automatic logic [2:0] kidx(input logic [4:0] r,
                                       input logic       dec);
      logic late;
      late = dec ? (r >= 5'd8) : (r >= 5'd24);
      return late ? ~r[2:0] : r[2:0];
   endfunction

   state_t         state_q, state_d;
   logic           dec_q, ctr_m_q;
   logic [255:0]   key_q;
   logic [63:0]    blk_q;
   logic [63:0]    a_q;
   logic [4:0]     rnd_q;
   logic [63:0]    cnt_q;
   logic [63:0]    oblock_q;
   logic [63:0]    a_nx;
   logic [63:0]    res;
   logic [4:0]     ri;
   logic [31:0]    k;
   logic           accept;
   logic           last;

   assign accept = ivalid && (state_q == IDLE);
   assign last   = (state_q == RUN) &&
                   ({1'b0, rnd_q} + 6'(R) == 6'd32);
   assign res    = {a_nx[31:0], a_nx[63:32]};
   assign oblock = oblock_q;

   // Unrolled Feistel rounds for this RUN clock.
   always_comb begin
      a_nx = a_q;
      ri   = '0;
      k    = '0;
      for (int j = 0; j < R; j++) begin
         ri   = rnd_q + 5'(j);
         k    = key_q[{~kidx(ri, dec_q), 5'd0} +: 32];
         a_nx = {a_nx[31:0], a_nx[63:32] ^ g_fn(a_nx[31:0], k)};
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d = state_q;
      oready  = 1'b0;
      ovalid  = 1'b0;
      obusy   = 1'b0;
      unique case (state_q)
         IDLE: begin
            oready = 1'b1;
            if (ivalid) state_d = RUN;
         end
         RUN: begin
            obusy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            obusy  = 1'b1;
            ovalid = 1'b1;
            if (iready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iclk) begin
      if (!irst_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Block capture, round iteration, result and CTR counter.
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         dec_q    <= 1'b0;
         ctr_m_q  <= 1'b0;
         key_q    <= '0;
         blk_q    <= '0;
         a_q      <= '0;
         rnd_q    <= '0;
         cnt_q    <= '0;
         oblock_q <= '0;
      end else begin
         if (state_q == IDLE && iiv_load)
            cnt_q <= {iiv, 32'h0};
         if (accept) begin
            dec_q   <= (imode == 2'b01);
            ctr_m_q <= (imode == 2'b10);
            key_q   <= ikey;
            blk_q   <= iblock;
            rnd_q   <= '0;
            if (imode == 2'b10)
               a_q <= iiv_load ? {iiv, 32'h0} : cnt_q;
            else
               a_q <= iblock;
         end else if (state_q == RUN) begin
            a_q   <= a_nx;
            rnd_q <= rnd_q + 5'(R);
            if (last) begin
               oblock_q <= ctr_m_q ? (res ^ blk_q) : res;
               if (ctr_m_q) cnt_q <= cnt_q + 64'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gost_engine.sv
// Scoreboard bench for gost_engine: four instances (1, 2, 4, 8 rounds
// per clock) share stimulus; a monitor checks results and latency.
module tb_gost_engine;

   localparam logic [255:0] KEY =
      256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [63:0] PT = 64'hfedcba9876543210;
   localparam logic [63:0] CT = 64'h4ee901e5c2d8ca3d;
   localparam logic [63:0] P1 = 64'h92def06b3c130a59;
   localparam logic [63:0] C1 = 64'h4e98110c97b7b93c;
   localparam logic [63:0] P2 = 64'hdb54c704f8189d20;
   localparam logic [63:0] C2 = 64'h3e250d93d6e85d69;
   localparam logic [63:0] P3 = 64'h4a98fb2e67a8024c;
   localparam logic [63:0] C3 = 64'h136d868807b2dbef;

   logic         clk;
   logic         irst_n;
   logic [1:0]   imode;
   logic [255:0] ikey;
   logic [31:0]  iiv;
   logic         iiv_load;
   logic [63:0]  iblock;
   logic         ivalid;
   logic         iready;
   logic [3:0]   rdy;
   logic [3:0]   vld;
   logic [3:0]   bsy;
   logic [63:0]  ob [4];

   int           checks;
   int           errors;
   int           cyc;
   int           acc [4];
   logic [3:0]   pv;
   logic [63:0]  pob [4];
   logic         pir;
   logic [63:0]  q [4][$];

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      gost_engine #(.ROUNDS_PER_CYCLE(1 << gi)) u_dut (
         .iclk     (clk),
         .irst_n   (irst_n),
         .imode    (imode),
         .ikey     (ikey),
         .iiv      (iiv),
         .iiv_load (iiv_load),
         .iblock   (iblock),
         .ivalid   (ivalid),
         .oready   (rdy[gi]),
         .oblock   (ob[gi]),
         .ovalid   (vld[gi]),
         .iready   (iready),
         .obusy    (bsy[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: latency at ovalid rise, hold under backpressure, scoreboard pop.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (irst_n && ivalid && rdy[i]) acc[i] = cyc;
         if (irst_n && vld[i] && !pv[i])
            chk($sformatf("latency_r%0d", 1 << i),
                64'(cyc - acc[i] - 1), 64'(32 >> i));
         if (vld[i] && pv[i] && !pir)
            chk($sformatf("hold_r%0d", 1 << i), ob[i], pob[i]);
         if (irst_n && vld[i] && iready) begin
            if (q[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_r%0d: got %h expected none",
                        1 << i, ob[i]);
            end else begin
               chk($sformatf("result_r%0d", 1 << i), ob[i], q[i].pop_front());
            end
         end
         pv[i]  = (vld[i] === 1'b1);
         pob[i] = ob[i];
      end
      pir = iready;
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (rdy !== 4'hf) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 200) begin
            chk("idle_timeout", 64'(rdy), 64'hf);
            return;
         end
      end
   endtask

   // Issue one block; afterwards scribble key/block and pulse ivalid
   // (and optionally iiv_load) while every instance is still in RUN.
   task automatic send(input logic [1:0] m, input logic [63:0] b,
                       input logic ld, input logic [31:0] iv,
                       input logic poke, input logic push,
                       input logic [63:0] exp);
      wait_idle();
      imode    = m;
      ikey     = KEY;
      iblock   = b;
      iiv      = iv;
      iiv_load = ld;
      ivalid   = 1'b1;
      if (push)
         for (int i = 0; i < 4; i++) q[i].push_back(exp);
      @(posedge clk);
      #1;
      ikey     = ~KEY;
      iblock   = {$urandom, $urandom};
      iiv      = 32'hdeadbeef;
      iiv_load = poke;
      imode    = 2'b01;
      repeat (2) @(posedge clk);
      #1;
      ivalid   = 1'b0;
      iiv_load = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_oready"}, 64'(rdy[i]), 64'd1);
         chk({tag, "_obusy"},  64'(bsy[i]), 64'd0);
         chk({tag, "_ovalid"}, 64'(vld[i]), 64'd0);
         chk({tag, "_oblock"}, ob[i], 64'd0);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      pv       = '0;
      pir      = 1'b0;
      irst_n   = 1'b0;
      imode    = 2'b00;
      ikey     = KEY;
      iiv      = '0;
      iiv_load = 1'b0;
      iblock   = '0;
      ivalid   = 1'b0;
      iready   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         acc[i] = 0;
         pob[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      irst_n = 1'b1;
      chk_reset_outputs("reset");

      send(2'b00, PT, 1'b0, 32'h0, 1'b0, 1'b1, CT);
      send(2'b01, CT, 1'b0, 32'h0, 1'b0, 1'b1, PT);
      send(2'b11, PT, 1'b0, 32'h0, 1'b0, 1'b1, CT);

      send(2'b10, P1, 1'b1, 32'h12345678, 1'b0, 1'b1, C1);
      send(2'b10, P2, 1'b0, 32'h0, 1'b1, 1'b1, C2);
      send(2'b10, P3, 1'b0, 32'h0, 1'b0, 1'b1, C3);

      wait_idle();
      iready = 1'b0;
      send(2'b00, PT, 1'b0, 32'h0, 1'b0, 1'b1, CT);
      for (int n = 0; n < 100 && vld !== 4'hf; n++) begin
         @(posedge clk);
         #1;
      end
      chk("bp_all_valid", 64'(vld), 64'hf);
      for (int c = 0; c < 10; c++) begin
         ivalid = 1'b1;
         iblock = {$urandom, $urandom};
         @(posedge clk);
         #1;
         chk("bp_oready", 64'(rdy), 64'h0);
         chk("bp_ovalid", 64'(vld), 64'hf);
         chk("bp_oblock_r1", ob[0], CT);
      end
      ivalid = 1'b0;
      iready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_oready", 64'(rdy), 64'hf);
      chk("bp_release_ovalid", 64'(vld), 64'h0);

      iready = 1'b0;
      send(2'b00, PT, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      repeat (10) @(posedge clk);
      #1;
      irst_n = 1'b0;
      @(posedge clk);
      #1;
      irst_n = 1'b1;
      iready = 1'b1;
      chk_reset_outputs("midrun_reset");

      send(2'b00, PT, 1'b0, 32'h0, 1'b0, 1'b1, CT);
      wait_idle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         chk($sformatf("drained_r%0d", 1 << i), 64'(q[i].size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
